frame_buf_bank_ctrl: RTL

FRAME_BUF_BANK_CTRL -- requirements
Module: frame_buf_bank_ctrl

---
 rtl/frame_buf_bank_ctrl_if.sv | 33 +++
 rtl/frame_buf_bank_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/frame_buf_bank_ctrl_if.sv
// frame_buf_bank_ctrl_if: frame pulses in, bank selection / base addresses / enables out
// Ports: i_wr_vs, i_wr_done, i_rd_vs, i_frame_stable (to controller);
//        o_wr_bank, o_rd_bank, o_wr_base, o_rd_base, o_wr_en, o_rd_en, o_state
//        and, with FRAME_STAT_EN, o_drop_cnt / o_rpt_cnt (from controller).
// master = frame timing source, slave = bank controller.
interface frame_buf_bank_ctrl_if #(parameter int ADDR_W = 32);
  logic              i_wr_vs;
  logic              i_wr_done;
  logic              i_rd_vs;
  logic              i_frame_stable;
  logic [1:0]        o_wr_bank;
  logic [1:0]        o_rd_bank;
  logic [ADDR_W-1:0] o_wr_base;
  logic [ADDR_W-1:0] o_rd_base;
  logic              o_wr_en;
  logic              o_rd_en;
  logic [1:0]        o_state;
`ifdef FRAME_STAT_EN
  logic [15:0]       o_drop_cnt;
  logic [15:0]       o_rpt_cnt;
  modport master (output i_wr_vs, i_wr_done, i_rd_vs, i_frame_stable,
                  input o_wr_bank, o_rd_bank, o_wr_base, o_rd_base, o_wr_en, o_rd_en, o_state,
                  o_drop_cnt, o_rpt_cnt);
  modport slave (input i_wr_vs, i_wr_done, i_rd_vs, i_frame_stable,
                 output o_wr_bank, o_rd_bank, o_wr_base, o_rd_base, o_wr_en, o_rd_en, o_state,
                 o_drop_cnt, o_rpt_cnt);
`else
  modport master (output i_wr_vs, i_wr_done, i_rd_vs, i_frame_stable,
                  input o_wr_bank, o_rd_bank, o_wr_base, o_rd_base, o_wr_en, o_rd_en, o_state);
  modport slave (input i_wr_vs, i_wr_done, i_rd_vs, i_frame_stable,
                 output o_wr_bank, o_rd_bank, o_wr_base, o_rd_base, o_wr_en, o_rd_en, o_state);
`endif
endinterface

// File: rtl/frame_buf_bank_ctrl.sv
// frame_buf_bank_ctrl: triple-buffer bank arbiter between a frame writer and a frame reader
// Ports: clk, rst_n (asynchronous, active-low), bus (frame_buf_bank_ctrl_if.slave):
//   frame start/done pulses and stable flag in; write/read bank, base, enable and FSM state out.
// Optional macro FRAME_STAT_EN adds saturating dropped/repeated frame counters.
module frame_buf_bank_ctrl #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] BANK_STRIDE = 32'h0080_0000
) (
  input logic clk,
  input logic rst_n,
  frame_buf_bank_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;
  state_t state, state_n;
  logic [1:0] wr_bank, rd_bank, lc, wr_bank_n, rd_bank_n, lc_n, eff_lc, rd_upd, wr_pick;
  logic lc_valid, lc_valid_n, done_flag, done_flag_n, wr_en_n, rd_en_n;
  logic live, eff_valid, rd_evt, rd_load, wr_evt, completed;
  assign wr_bank = bus.o_wr_bank;
  assign rd_bank = bus.o_rd_bank;
  assign bus.o_state = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE) ? ((bus.i_wr_vs && bus.i_frame_stable) ? ARM : IDLE) :
              !bus.i_frame_stable ? IDLE :
              (state == ARM && bus.i_wr_done) ? RUN : state;
  // A completion in the same cycle is visible to read and write selection (eff_lc).
  // The write bank avoids the old read bank, the new read bank and the last complete bank;
  // at most two of those are distinct, so one bank is always free.
  always_comb begin
    live        = state != IDLE && bus.i_frame_stable;
    eff_lc      = bus.i_wr_done ? wr_bank : lc;
    eff_valid   = bus.i_wr_done || lc_valid;
    rd_evt      = live && state == RUN && bus.i_rd_vs;
    rd_load     = rd_evt && (!bus.o_rd_en || (eff_valid && eff_lc != rd_bank));
    rd_upd      = rd_load ? eff_lc : rd_bank;
    wr_evt      = live && bus.i_wr_vs;
    completed   = done_flag || bus.i_wr_done;
    wr_pick     = (rd_bank != 2'd0 && rd_upd != 2'd0 && eff_lc != 2'd0) ? 2'd0 :
                  (rd_bank != 2'd1 && rd_upd != 2'd1 && eff_lc != 2'd1) ? 2'd1 : 2'd2;
    wr_bank_n   = !live ? 2'd0 : (wr_evt && completed) ? wr_pick : wr_bank;
    rd_bank_n   = live ? rd_upd : 2'd0;
    lc_n        = live ? eff_lc : 2'd0;
    lc_valid_n  = live && eff_valid;
    done_flag_n = live && !bus.i_wr_vs && completed;
    wr_en_n     = live || (state == IDLE && bus.i_wr_vs && bus.i_frame_stable);
    rd_en_n     = live && (bus.o_rd_en || rd_evt);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.o_wr_bank <= 2'd0;
      bus.o_rd_bank <= 2'd0;
      bus.o_wr_base <= '0;
      bus.o_rd_base <= '0;
      bus.o_wr_en   <= 1'b0;
      bus.o_rd_en   <= 1'b0;
      lc            <= 2'd0;
      lc_valid      <= 1'b0;
      done_flag     <= 1'b0;
    end else begin
      bus.o_wr_bank <= wr_bank_n;
      bus.o_rd_bank <= rd_bank_n;
      bus.o_wr_base <= ADDR_W'(wr_bank_n) * ADDR_W'(BANK_STRIDE);
      bus.o_rd_base <= ADDR_W'(rd_bank_n) * ADDR_W'(BANK_STRIDE);
      bus.o_wr_en   <= wr_en_n;
      bus.o_rd_en   <= rd_en_n;
      lc            <= lc_n;
      lc_valid      <= lc_valid_n;
      done_flag     <= done_flag_n;
    end
`ifdef FRAME_STAT_EN
  logic drop_ev, rpt_ev;
  assign drop_ev = wr_evt && !completed;
  assign rpt_ev  = rd_evt && !rd_load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.o_drop_cnt <= 16'd0;
      bus.o_rpt_cnt  <= 16'd0;
    end else begin
      bus.o_drop_cnt <= !live ? 16'd0 : (drop_ev && bus.o_drop_cnt != 16'hFFFF) ? bus.o_drop_cnt + 16'd1 : bus.o_drop_cnt;
      bus.o_rpt_cnt  <= !live ? 16'd0 : (rpt_ev && bus.o_rpt_cnt != 16'hFFFF) ? bus.o_rpt_cnt + 16'd1 : bus.o_rpt_cnt;
    end
`endif
endmodule
